// File: rtl/dpbram_wr_arbiter.sv
// Round-robin, burst-granular arbiter sharing the Zynq-side DPBRAM write port
// between two requesters, followed by a w_valid/w_ready mailbox handoff to the DSP.
module dpbram_wr_arbiter #(
   parameter int ADDR_W      = 9,
   parameter int LEN_W       = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [1:0]        i_req,
   input  logic [ADDR_W-1:0] i_base_addr0,
   input  logic [LEN_W-1:0]  i_len0,
   input  logic [ADDR_W-1:0] i_base_addr1,
   input  logic [LEN_W-1:0]  i_len1,
   input  logic [15:0]       i_wdata0,
   input  logic [15:0]       i_wdata1,
   output logic [1:0]        o_gnt,
   output logic [LEN_W-1:0]  o_word_idx,
   output logic [1:0]        o_done,
   output logic [ADDR_W-1:0] o_xintf_z_to_d_addr,
   output logic [15:0]       o_xintf_z_to_d_din,
   output logic              o_xintf_z_to_d_ce,
   output logic              o_w_valid,
   input  logic              i_w_ready,
   output logic              o_timeout,
   output logic              o_busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      BURST,
      W_HANDOFF,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic              sel_q, sel_d;
   logic              last_q, last_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       din_q, din_d;
   logic              ce_q, ce_d;
   logic              wvalid_q, wvalid_d;
   logic              timeout_q, timeout_d;
   logic [LEN_W-1:0]  winLen;

   // last_q resets to 1 so that requester 0 wins the very first tie.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         sel_q     <= 1'b0;
         last_q    <= 1'b1;
         base_q    <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         addr_q    <= '0;
         din_q     <= '0;
         ce_q      <= 1'b0;
         wvalid_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         last_q    <= last_d;
         base_q    <= base_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         ce_q      <= ce_d;
         wvalid_q  <= wvalid_d;
         timeout_q <= timeout_d;
      end
   end

   assign winLen = sel_q ? i_len1 : i_len0;

   // Ready is only honoured once w_valid is visible to the DSP, so the last
   // write strobe has always retired before the mailbox is raised.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      last_d    = last_q;
      base_d    = base_q;
      len_d     = len_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      din_d     = din_q;
      ce_d      = 1'b0;
      wvalid_d  = wvalid_q;
      timeout_d = timeout_q;
      case (state_q)
         IDLE: begin
            if (i_req != 2'b00) begin
               sel_d   = (i_req == 2'b11) ? ~last_q : i_req[1];
               state_d = GRANT;
            end
         end
         GRANT: begin
            base_d  = sel_q ? i_base_addr1 : i_base_addr0;
            len_d   = winLen;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = (winLen == '0) ? DONE : BURST;
         end
         BURST: begin
            addr_d = base_q + ADDR_W'(idx_q);
            din_d  = sel_q ? i_wdata1 : i_wdata0;
            ce_d   = 1'b1;
            idx_d  = idx_q + LEN_W'(1);
            if (idx_q == len_q - LEN_W'(1)) begin
               state_d = W_HANDOFF;
            end
         end
         W_HANDOFF: begin
            wvalid_d = 1'b1;
            if (wvalid_q) begin
               if (i_w_ready) begin
                  wvalid_d = 1'b0;
                  state_d  = DONE;
               end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                  wvalid_d  = 1'b0;
                  timeout_d = 1'b1;
                  state_d   = DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         DONE: begin
            last_d  = sel_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign o_busy              = (state_q != IDLE);
   assign o_gnt               = o_busy ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
   assign o_done              = (state_q == DONE) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
   assign o_word_idx          = idx_q;
   assign o_xintf_z_to_d_addr = addr_q;
   assign o_xintf_z_to_d_din  = din_q;
   assign o_xintf_z_to_d_ce   = ce_q;
   assign o_w_valid           = wvalid_q;
   assign o_timeout           = timeout_q;

endmodule

// File: tb/tb_dpbram_wr_arbiter.sv
// Bench for dpbram_wr_arbiter: directed burst table, alternating-grant and
// mid-burst reset sequences, and randomized rounds against a burst-level model.
module tb_dpbram_wr_arbiter;

   localparam int ADDR_W = 9;
   localparam int LEN_W  = 8;
   localparam int TO_CYC = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        reqI;
   logic [ADDR_W-1:0] baseArr [2];
   logic [LEN_W-1:0]  lenArr  [2];
   logic [15:0]       dbArr   [2];
   logic [15:0]       wdata0, wdata1;
   logic              wReady;
   logic [1:0]        gnt, done;
   logic [LEN_W-1:0]  wordIdx;
   logic [ADDR_W-1:0] wrAddr;
   logic [15:0]       wrDin;
   logic              wrCe, wValid, timeoutO, busy;

   int checksTotal  = 0;
   int checksPassed = 0;
   int modelLast    = 1;

   typedef struct {
      int r;
      int base;
      int len;
      int db;
      int rdyDelay;
      int expGnt;
      int expCe;
      int expFirst;
      int expLast;
      int expValid;
      int expBusy;
      int expTimeout;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   // Requesters present their word combinationally from the fetched index.
   assign wdata0 = dbArr[0] + 16'(wordIdx);
   assign wdata1 = dbArr[1] + 16'(wordIdx);

   dpbram_wr_arbiter #(
      .ADDR_W(ADDR_W),
      .LEN_W(LEN_W),
      .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_req(reqI),
      .i_base_addr0(baseArr[0]),
      .i_len0(lenArr[0]),
      .i_base_addr1(baseArr[1]),
      .i_len1(lenArr[1]),
      .i_wdata0(wdata0),
      .i_wdata1(wdata1),
      .o_gnt(gnt),
      .o_word_idx(wordIdx),
      .o_done(done),
      .o_xintf_z_to_d_addr(wrAddr),
      .o_xintf_z_to_d_din(wrDin),
      .o_xintf_z_to_d_ce(wrCe),
      .o_w_valid(wValid),
      .i_w_ready(wReady),
      .o_timeout(timeoutO),
      .o_busy(busy)
   );

   function automatic int onehot(input int r);
      return (r == 1) ? 2 : 1;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      checksTotal++;
      if (act == exp) checksPassed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // One isolated burst from a single requester, summarized and compared to a table row.
   task automatic applyStimulus(input vec_t v);
      int busyCyc = 0, ceCnt = 0, vCyc = 0, vcnt = 0, cyc = 0;
      int first = 0, last = 0, gntSeen = 0, doneMask = 0, dataErr = 0, overlap = 0;
      bit seenBusy = 0;
      baseArr[v.r] = ADDR_W'(v.base);
      lenArr[v.r]  = LEN_W'(v.len);
      dbArr[v.r]   = 16'(v.db);
      wReady       = 1'b0;
      @(negedge clk);
      reqI[v.r] = 1'b1;
      while (cyc < 400 && !(seenBusy && !busy)) begin
         @(negedge clk);
         cyc++;
         if (busy) begin
            if (!seenBusy) gntSeen = int'(gnt);
            seenBusy = 1;
            busyCyc++;
         end
         if (wrCe) begin
            if (ceCnt == 0) first = int'(wrAddr);
            last = int'(wrAddr);
            if (int'(wrAddr) != (v.base + ceCnt) % 512 || int'(wrDin) != ((v.db + ceCnt) & 'hFFFF))
               dataErr++;
            if (wValid) overlap++;
            ceCnt++;
         end
         if (wValid) begin
            vCyc++;
            wReady = (v.rdyDelay >= 0 && vcnt >= v.rdyDelay);
            vcnt++;
         end else begin
            wReady = 1'b0;
         end
         doneMask = doneMask | int'(done);
         reqI = reqI & ~done;
      end
      reqI[v.r] = 1'b0;
      wReady = 1'b0;
      modelLast = v.r;
      checkOutput("vecBudget", int'(cyc < 400), 1);
      checkOutput("vecGnt", gntSeen, v.expGnt);
      checkOutput("vecCeCount", ceCnt, v.expCe);
      checkOutput("vecFirstAddr", first, v.expFirst);
      checkOutput("vecLastAddr", last, v.expLast);
      checkOutput("vecDataErrors", dataErr, 0);
      checkOutput("vecCeValidOverlap", overlap, 0);
      checkOutput("vecValidCycles", vCyc, v.expValid);
      checkOutput("vecBusyCycles", busyCyc, v.expBusy);
      checkOutput("vecDone", doneMask, v.expGnt);
      checkOutput("vecTimeout", int'(timeoutO), v.expTimeout);
   endtask

   // Raises the requesters in mask together; model predicts grant order and every write.
   task automatic runRound(input logic [1:0] mask, input bit randReady);
      int order[$];
      int expA[$];
      int expD[$];
      int cyc = 0, gntCnt = 0, doneCnt = 0, ceInBurst = 0, vcnt = 0, cur = 0;
      int firstR;
      logic [1:0] prevGnt = 2'b00;
      firstR = (mask == 2'b11) ? ((modelLast == 0) ? 1 : 0) : (mask[1] ? 1 : 0);
      order.push_back(firstR);
      if (mask == 2'b11) order.push_back(1 - firstR);
      foreach (order[i]) begin
         for (int k = 0; k < int'(lenArr[order[i]]); k++) begin
            expA.push_back((int'(baseArr[order[i]]) + k) % 512);
            expD.push_back((int'(dbArr[order[i]]) + k) & 'hFFFF);
         end
      end
      modelLast = order[order.size() - 1];
      @(negedge clk);
      reqI = mask;
      while (doneCnt < order.size() && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (gnt != 2'b00 && prevGnt == 2'b00) begin
            if (gntCnt < order.size()) begin
               checkOutput("roundGnt", int'(gnt), onehot(order[gntCnt]));
               cur = order[gntCnt];
            end else begin
               checkOutput("roundExtraGnt", int'(gnt), 0);
            end
            gntCnt++;
            ceInBurst = 0;
         end
         if (wrCe) begin
            checkOutput("roundCeValidExcl", int'(wValid), 0);
            if (expA.size() == 0) begin
               checkOutput("roundUnexpectedWrite", int'(wrAddr), -1);
            end else begin
               checkOutput("roundAddr", int'(wrAddr), expA.pop_front());
               checkOutput("roundData", int'(wrDin), expD.pop_front());
            end
            // Burst parameters are latched at grant; changing them now must be harmless.
            if (ceInBurst == 0) begin
               baseArr[cur] = ADDR_W'($urandom);
               lenArr[cur]  = LEN_W'($urandom);
            end
            ceInBurst++;
         end
         if (done != 2'b00) begin
            if (doneCnt < order.size()) checkOutput("roundDone", int'(done), onehot(order[doneCnt]));
            doneCnt++;
            reqI = reqI & ~done;
         end
         vcnt = wValid ? vcnt + 1 : 0;
         wReady = randReady ? (($urandom_range(0, 1) == 1) || vcnt >= 8) : 1'b1;
         prevGnt = gnt;
      end
      reqI = 2'b00;
      checkOutput("roundBudget", int'(cyc < 300), 1);
      checkOutput("roundWritesLeft", expA.size(), 0);
   endtask

   initial begin
      int dn, ceTotal, cyc;
      logic [1:0] pend;

      vecs[0] = '{0,   8,  4, 'hA0,    1, 1,  4,   8,  11,  2,  9, 0};
      vecs[1] = '{1, 510,  4, 'h1230,  0, 2,  4, 510,   1,  1,  8, 0};
      vecs[2] = '{0, 100,  0, 'h0,     0, 1,  0,   0,   0,  0,  2, 0};
      vecs[3] = '{1, 511,  1, 'h5555,  3, 2,  1, 511, 511,  4,  8, 0};
      vecs[4] = '{0, 200, 16, 'h0F00, -1, 1, 16, 200, 215, 16, 35, 1};
      vecs[5] = '{1,   3,  2, 'h7700,  0, 2,  2,   3,   4,  1,  6, 1};

      rst = 1'b1;
      reqI = 2'b00;
      wReady = 1'b0;
      for (int r = 0; r < 2; r++) begin
         baseArr[r] = '0;
         lenArr[r]  = '0;
         dbArr[r]   = '0;
      end
      #12;
      checkOutput("rstGnt", int'(gnt), 0);
      checkOutput("rstDone", int'(done), 0);
      checkOutput("rstCe", int'(wrCe), 0);
      checkOutput("rstValid", int'(wValid), 0);
      checkOutput("rstTimeout", int'(timeoutO), 0);
      checkOutput("rstBusy", int'(busy), 0);
      checkOutput("rstWordIdx", int'(wordIdx), 0);
      checkOutput("rstAddr", int'(wrAddr), 0);
      checkOutput("rstDin", int'(wrDin), 0);
      @(negedge clk);
      rst = 1'b0;

      // Both requesters from reset, re-requesting right after each completion.
      baseArr[0] = 9'd16; lenArr[0] = 8'd2; dbArr[0] = 16'h0100;
      baseArr[1] = 9'd32; lenArr[1] = 8'd2; dbArr[1] = 16'h0200;
      wReady = 1'b1;
      @(negedge clk);
      reqI = 2'b11;
      dn = 0; ceTotal = 0; cyc = 0; pend = 2'b00;
      while (dn < 4 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         reqI = reqI | pend;
         pend = 2'b00;
         if (wrCe) ceTotal++;
         if (done != 2'b00) begin
            checkOutput("altDone", int'(done), (dn % 2 == 0) ? 1 : 2);
            dn++;
            reqI = reqI & ~done;
            if (dn < 4) pend = done;
            else reqI = 2'b00;
         end
      end
      reqI = 2'b00;
      modelLast = 1;
      checkOutput("altBudget", int'(cyc < 200), 1);
      checkOutput("altCeTotal", ceTotal, 8);

      for (int n = 0; n < 25; n++) begin
         for (int r = 0; r < 2; r++) begin
            baseArr[r] = ADDR_W'($urandom);
            lenArr[r]  = LEN_W'($urandom_range(0, 6));
            dbArr[r]   = 16'($urandom);
         end
         runRound(2'($urandom_range(1, 3)), 1'b1);
      end
      checkOutput("randTimeoutClear", int'(timeoutO), 0);

      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

      // Reset lands on the third write strobe of a len-8 burst.
      baseArr[0] = 9'd40; lenArr[0] = 8'd8; dbArr[0] = 16'h4000;
      wReady = 1'b1;
      @(negedge clk);
      reqI = 2'b01;
      dn = 0; cyc = 0;
      while (dn < 3 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (wrCe) dn++;
      end
      checkOutput("rstMidBudget", int'(cyc < 40), 1);
      rst = 1'b1;
      reqI = 2'b00;
      #1;
      checkOutput("rstMidGnt", int'(gnt), 0);
      checkOutput("rstMidCe", int'(wrCe), 0);
      checkOutput("rstMidValid", int'(wValid), 0);
      checkOutput("rstMidBusy", int'(busy), 0);
      checkOutput("rstMidTimeout", int'(timeoutO), 0);
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         dn = dn + int'(done != 2'b00) + int'(busy);
      end
      checkOutput("rstMidQuiet", dn, 0);
      modelLast = 1;
      baseArr[0] = 9'd40; lenArr[0] = 8'd3;
      baseArr[1] = 9'd20; lenArr[1] = 8'd1;
      runRound(2'b11, 1'b0);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
